// File: rtl/mem_read_arbiter.sv
// Multi-port memory read arbiter: grants one requester at a time,
// issues a single read and returns the word with a one-cycle rdy pulse.
module mem_read_arbiter #(
  parameter int NUM_PORTS     = 8,
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 8,
  parameter int MEMORY_SIZE   = 7200,
  parameter int READ_LATENCY  = 1,
  parameter int ARB_MODE      = 0
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NUM_PORTS-1:0]               data_req,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] data_addr,
  output logic [DATA_WIDTH-1:0]              data,
  output logic [NUM_PORTS-1:0]               data_rdy,
  output logic                               mem_re,
  output logic [ADDRESS_WIDTH-1:0]           mem_raddr,
  input  logic [DATA_WIDTH-1:0]              mem_rdata
);

  localparam int PW =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW-1:0] LAST_PORT =
    PW'(NUM_PORTS - 1);
  localparam logic [ADDRESS_WIDTH:0] MEM_SIZE =
    (ADDRESS_WIDTH + 1)'(MEMORY_SIZE);
  localparam logic [1:0] WAIT_LAST =
    2'(READ_LATENCY - 2);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    CAPTURE,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [PW-1:0]            grant_q, grant_d;
  logic [PW-1:0]            last_q, last_d;
  logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
  logic                     oor_q, oor_d;
  logic                     re_q, re_d;
  logic [NUM_PORTS-1:0]     rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [1:0]               cnt_q, cnt_d;

  logic [PW-1:0]            grant;
  logic                     any_req;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic                     sel_oor;

  // Reverse scan so the nearest candidate is written last and wins.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = |data_req;
    if (ARB_MODE == 1) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (data_req[i]) grant = PW'(i);
      end
    end else begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = (int'(last_q) + k) % NUM_PORTS;
        if (data_req[idx]) grant = PW'(idx);
      end
    end
  end

  assign sel_addr =
    data_addr[int'(grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign sel_oor = {1'b0, sel_addr} >= MEM_SIZE;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    raddr_d = raddr_q;
    oor_d   = oor_q;
    re_d    = 1'b0;
    rdy_d   = '0;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = READ;
          grant_d = grant;
          raddr_d = sel_addr;
          oor_d   = sel_oor;
          re_d    = !sel_oor;
          if (ARB_MODE == 0) last_d = grant;
        end
      end
      READ: begin
        cnt_d   = '0;
        state_d = (READ_LATENCY > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == WAIT_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d         = oor_q ? '0 : mem_rdata;
        rdy_d[grant_q] = 1'b1;
        state_d        = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_PORT;
      raddr_q <= '0;
      oor_q   <= 1'b0;
      re_q    <= 1'b0;
      rdy_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      raddr_q <= raddr_d;
      oor_q   <= oor_d;
      re_q    <= re_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data      = data_q;
  assign data_rdy  = rdy_q;
  assign mem_re    = re_q;
  assign mem_raddr = raddr_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: three instances (RR L=1, RR L=3,
// fixed-priority L=1), each with a latency-accurate memory model.
module tb_mem_read_arbiter;

  localparam int NP = 8;
  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    req   [3];
  logic [NP*AW-1:0] addr  [3];
  logic [DW-1:0]    dout  [3];
  logic [NP-1:0]    rdy   [3];
  logic             re    [3];
  logic [AW-1:0]    raddr [3];
  logic [DW-1:0]    rdata [3];
  logic [DW-1:0]    pipe  [3][3];

  int checks = 0;
  int passed = 0;

  function automatic logic [7:0] memf(input logic [AW-1:0] a);
    if (a == 13'd100) return 8'hA5;
    return a[7:0] ^ 8'h3C;
  endfunction

  // Synchronous memory: word appears L cycles after the mem_re cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pipe[i][0] <= re[i] ? memf(raddr[i]) : 8'hEE;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign rdata[0] = pipe[0][0];
  assign rdata[1] = pipe[1][2];
  assign rdata[2] = pipe[2][0];

  mem_read_arbiter #(.READ_LATENCY(1), .ARB_MODE(0)) u_rr (
    .clk(clk), .resetn(resetn),
    .data_req(req[0]), .data_addr(addr[0]),
    .data(dout[0]), .data_rdy(rdy[0]),
    .mem_re(re[0]), .mem_raddr(raddr[0]),
    .mem_rdata(rdata[0])
  );

  mem_read_arbiter #(.READ_LATENCY(3), .ARB_MODE(0)) u_l3 (
    .clk(clk), .resetn(resetn),
    .data_req(req[1]), .data_addr(addr[1]),
    .data(dout[1]), .data_rdy(rdy[1]),
    .mem_re(re[1]), .mem_raddr(raddr[1]),
    .mem_rdata(rdata[1])
  );

  mem_read_arbiter #(.READ_LATENCY(1), .ARB_MODE(1)) u_fp (
    .clk(clk), .resetn(resetn),
    .data_req(req[2]), .data_addr(addr[2]),
    .data(dout[2]), .data_rdy(rdy[2]),
    .mem_re(re[2]), .mem_raddr(raddr[2]),
    .mem_rdata(rdata[2])
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int d, input int p,
                          input int a);
    addr[d][p*AW +: AW] = AW'(a);
  endtask

  typedef struct {
    int         port;
    int         a;
    logic       exp_re;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vt [6];

  initial begin
    int n;
    int lastc;
    for (int d = 0; d < 3; d++) begin
      req[d]  = '0;
      addr[d] = '0;
    end

    vt[0] = '{3, 100,  1'b1, 8'hA5};
    vt[1] = '{1, 7200, 1'b0, 8'h00};
    vt[2] = '{0, 7199, 1'b1, 8'h23};
    vt[3] = '{7, 0,    1'b1, 8'h3C};
    vt[4] = '{5, 8191, 1'b0, 8'h00};
    vt[5] = '{2, 4095, 1'b1, 8'hC3};

    step;
    step;
    for (int d = 0; d < 3; d++) begin
      chk("rst_data",  32'(dout[d]),  0);
      chk("rst_rdy",   32'(rdy[d]),   0);
      chk("rst_re",    32'(re[d]),    0);
      chk("rst_raddr", 32'(raddr[d]), 0);
    end
    resetn = 1'b1;
    step;

    // Single reads on the round-robin instance
    for (int v = 0; v < 6; v++) begin
      set_addr(0, vt[v].port, vt[v].a);
      req[0][vt[v].port] = 1'b1;
      step;
      chk("vec_re_c1",    32'(re[0]),    32'(vt[v].exp_re));
      chk("vec_raddr_c1", 32'(raddr[0]), 32'(vt[v].a % 8192));
      chk("vec_rdy_c1",   32'(rdy[0]),   0);
      req[0] = '0;
      step;
      chk("vec_re_c2",    32'(re[0]),    0);
      chk("vec_rdy_c2",   32'(rdy[0]),   0);
      step;
      chk("vec_rdy_c3",   32'(rdy[0]),   32'(1 << vt[v].port));
      chk("vec_data_c3",  32'(dout[0]),  32'(vt[v].exp_d));
      step;
      chk("vec_rdy_c4",   32'(rdy[0]),   0);
      chk("vec_hold_c4",  32'(dout[0]),  32'(vt[v].exp_d));
    end

    // Round-robin rotation from a fresh reset
    resetn = 1'b0;
    step;
    resetn = 1'b1;
    step;
    for (int p = 0; p < NP; p++) set_addr(0, p, 10*p + 1);
    req[0] = 8'hFF;
    n = 0;
    lastc = 0;
    for (int c = 1; c <= 36; c++) begin
      step;
      req[0] = 8'hFF;
      if (rdy[0] != '0) begin
        if (n < 9) begin
          chk("rr_port", 32'(rdy[0]), 32'(1 << (n % 8)));
          chk("rr_data", 32'(dout[0]),
              32'(memf(AW'(10*(n % 8) + 1))));
          if (n == 0) chk("rr_first", c, 3);
          else        chk("rr_gap", c - lastc, 4);
        end
        lastc = c;
        n++;
        req[0] = ~rdy[0];
      end
    end
    chk("rr_count", n, 9);
    req[0] = '0;
    repeat (6) step;

    // Fixed priority: port 2 starves port 5 until it stops
    set_addr(2, 2, 200);
    set_addr(2, 5, 300);
    req[2] = 8'h24;
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      step;
      if (rdy[2] != '0) begin
        if (n < 3) begin
          chk("fp_port2", 32'(rdy[2]), 32'h04);
          chk("fp_data2", 32'(dout[2]), 32'hF4);
        end else begin
          chk("fp_port5", 32'(rdy[2]), 32'h20);
          chk("fp_data5", 32'(dout[2]), 32'h10);
        end
        n++;
        req[2] = (n < 3) ? 8'h24 : (n == 3 ? 8'h20 : 8'h00);
      end
    end
    chk("fp_count", n, 4);
    req[2] = '0;
    repeat (3) step;

    // Latency 3, req dropped and addr changed after grant
    set_addr(1, 0, 7199);
    req[1] = 8'h01;
    step;
    chk("l3_re_c1", 32'(re[1]), 1);
    chk("l3_raddr_c1", 32'(raddr[1]), 7199);
    req[1] = '0;
    set_addr(1, 0, 5);
    for (int c = 2; c <= 4; c++) begin
      step;
      chk("l3_re_wait",    32'(re[1]),    0);
      chk("l3_raddr_wait", 32'(raddr[1]), 7199);
      chk("l3_rdy_wait",   32'(rdy[1]),   0);
    end
    step;
    chk("l3_rdy_c5",  32'(rdy[1]),  32'h01);
    chk("l3_data_c5", 32'(dout[1]), 32'h23);
    step;
    chk("l3_rdy_c6",  32'(rdy[1]),  0);

    // Reset while in WAIT aborts, then a normal grant follows
    set_addr(1, 6, 50);
    req[1] = 8'h40;
    step;
    step;
    req[1] = '0;
    resetn = 1'b0;
    #1;
    chk("rw_data",  32'(dout[1]),  0);
    chk("rw_rdy",   32'(rdy[1]),   0);
    chk("rw_re",    32'(re[1]),    0);
    chk("rw_raddr", 32'(raddr[1]), 0);
    for (int c = 0; c < 4; c++) begin
      step;
      chk("rw_no_rdy", 32'(rdy[1]), 0);
    end
    resetn = 1'b1;
    req[1] = 8'h40;
    step;
    chk("rw_re_c1",    32'(re[1]),    1);
    chk("rw_raddr_c1", 32'(raddr[1]), 50);
    req[1] = '0;
    repeat (3) step;
    chk("rw_rdy_c4",  32'(rdy[1]),  0);
    step;
    chk("rw_rdy_c5",  32'(rdy[1]),  32'h40);
    chk("rw_data_c5", 32'(dout[1]), 32'h0E);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8: number of requester ports, legal range 1..16.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 13: width of every read address.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: width of read data.
REQ-004 SHALL have parameter MEMORY_SIZE, default 7200: number of valid words; addresses at or above this are out of range.
REQ-005 SHALL have parameter READ_LATENCY, default 1: cycles from address presented to mem_rdata valid, legal range 1..4.
REQ-006 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority, lowest index wins.
REQ-007 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-008 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-009 SHALL have port data_req, input, NUM_PORTS: per-port read request, level.
REQ-010 SHALL have port data_addr, input, NUM_PORTS*ADDRESS_WIDTH: port i address in bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-011 SHALL have port data, output, DATA_WIDTH: read data, shared by all ports.
REQ-012 SHALL have port data_rdy, output, NUM_PORTS: per-port one-cycle completion pulse, at most one bit set.
REQ-013 SHALL have port mem_re, output, 1: memory read enable.
REQ-014 SHALL have port mem_raddr, output, ADDRESS_WIDTH: memory read address.
REQ-015 SHALL have port mem_rdata, input, DATA_WIDTH: memory read data.

Function
REQ-016 SHALL implement states IDLE, READ, WAIT, CAPTURE, DONE.
REQ-017 IDLE: when any data_req bit is high, SHALL select grant g per ARB_MODE, register mem_raddr from port g's address, and go to READ; otherwise stay in IDLE.
REQ-018 Round-robin SHALL search from (last_grant+1) mod NUM_PORTS upward with wrap-around; last_grant updates on every grant.
REQ-019 Fixed priority SHALL grant the lowest-index requesting port; last_grant is unused.
REQ-020 READ: SHALL assert mem_re for exactly one cycle; next state is WAIT if READ_LATENCY>1, else CAPTURE.
REQ-021 WAIT: SHALL hold for READ_LATENCY-1 cycles total, then go to CAPTURE.
REQ-022 CAPTURE: SHALL register mem_rdata into data; next state DONE.
REQ-023 DONE: SHALL assert data_rdy[g] for exactly one cycle with data valid; next state IDLE unconditionally.
REQ-024 SHALL hold mem_raddr stable from READ through CAPTURE.
REQ-025 rdy latency SHALL be READ_LATENCY+2 cycles after the granting IDLE cycle; peak throughput is one read per READ_LATENCY+3 cycles.
REQ-026 SHALL ignore data_req while in DONE, so a requester that drops req on seeing rdy is never re-granted.
REQ-027 data SHALL hold its last value outside DONE.
REQ-028 Out-of-range address (>= MEMORY_SIZE): SHALL keep mem_re low in READ, load data with zero in CAPTURE, and keep the same timing and rdy pulse.
REQ-029 A req deasserted mid-transaction SHALL NOT abort the transaction; data_rdy[g] still pulses.
REQ-030 data_addr changes after grant SHALL have no effect on the transaction in flight.
REQ-031 Port-index arithmetic SHALL use $clog2(NUM_PORTS) bits, minimum 1; NUM_PORTS=1 always grants port 0.

Reset
REQ-032 On resetn low, SHALL go to IDLE immediately and clear data_rdy, data, mem_re and mem_raddr to 0.
REQ-033 On resetn low, SHALL set last_grant to NUM_PORTS-1, so the first round-robin grant searches from port 0.
REQ-034 Reset mid-transaction SHALL abort with no data_rdy pulse.
REQ-035 The first grant SHALL occur no earlier than the first clk edge after resetn rises.

Verification
REQ-036 Single read: port 3 requests addr 100, mem[100]=0xA5, L=1 -> mem_re high in cycle 1 with mem_raddr=100; data_rdy=0x08 and data=0xA5 in cycle 3.
REQ-037 Round-robin: all 8 ports request continuously, each dropping req for one cycle after its rdy -> grants 0,1,...,7,0, one every 4 cycles.
REQ-038 Fixed priority (ARB_MODE=1): ports 2 and 5 requesting, port 2 re-requests after each rdy -> port 5 not granted until port 2 stops.
REQ-039 Latency: READ_LATENCY=3, port 0 requests addr 7199 -> rdy in cycle 5, data=mem[7199], mem_raddr held over cycles 1-4.
REQ-040 Out-of-range: port 1 requests addr 7200 -> mem_re never high; data_rdy=0x02 and data=0x00 in cycle 3.
REQ-041 Reset in WAIT (L=3): resetn low in cycle 2 -> all outputs 0 at once, no rdy; after release, a port 6 request is granted normally.
